// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic P_CPU = 1'b0;
  localparam logic P_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] grant_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags when TIMEOUT cycles pass without completion.
module mem_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count of cycles already spent in the current access.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th access cycle; a zero TIMEOUT never fires.
  assign expired_c = (TIMEOUT != 0) && en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the core (port 0) and an auxiliary master (port 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iP0_Read,
  input  logic              iP0_Write,
  input  logic [ADDR_W-1:0] iP0_Addr,
  input  logic [DATA_W-1:0] iP0_Data,
  output logic [DATA_W-1:0] oP0_Data,
  output logic              oP0_Rdy,
  output logic              oP0_Err,
  input  logic              iP1_Read,
  input  logic              iP1_Write,
  input  logic [ADDR_W-1:0] iP1_Addr,
  input  logic [DATA_W-1:0] iP1_Data,
  output logic [DATA_W-1:0] oP1_Data,
  output logic              oP1_Rdy,
  output logic              oP1_Err,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemRdy,
  output logic [1:0]        oGrant
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] p0_data_q, p0_data_d;
  logic [DATA_W-1:0] p1_data_q, p1_data_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              rdy0_q, rdy0_d;
  logic              rdy1_q, rdy1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [1:0]        grant_q, grant_d;

  logic req0_c, req1_c, win_aux_c, win_rd_c, win_wr_c;
  logic resp_err_c, wd_expired_c;

  // On a tie the port not granted last wins.
  assign req0_c    = iP0_Read | iP0_Write;
  assign req1_c    = iP1_Read | iP1_Write;
  assign win_aux_c = req1_c && (!req0_c || (ptr_q == P_CPU));
  assign win_rd_c  = win_aux_c ? iP1_Read  : iP0_Read;
  assign win_wr_c  = win_aux_c ? iP1_Write : iP0_Write;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (iClk),
    .rst       (iRst),
    .clr       (state_q != ACCESS),
    .en        (state_q == ACCESS),
    .expired_c (wd_expired_c)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    p0_data_d  = p0_data_q;
    p1_data_d  = p1_data_q;
    resp_err_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_c || req1_c) begin
          owner_d = win_aux_c;
          ptr_d   = win_aux_c;
          // Read and write together is illegal: answer with an error, never touch memory.
          if (win_rd_c && win_wr_c) begin
            state_d    = RESP;
            resp_err_c = 1'b1;
          end else begin
            state_d    = ACCESS;
            cmd_d.op   = win_wr_c ? OP_WRITE : OP_READ;
            cmd_d.addr = win_aux_c ? iP1_Addr : iP0_Addr;
            cmd_d.data = win_aux_c ? iP1_Data : iP0_Data;
          end
        end
      end
      ACCESS: begin
        if (iMemRdy) begin
          state_d = RESP;
          if (cmd_q.op == OP_READ) begin
            if (owner_q == P_AUX) p1_data_d = iMemData;
            else                  p0_data_d = iMemData;
          end
        end else if (wd_expired_c) begin
          state_d    = RESP;
          resp_err_c = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they align with the state they describe.
    mem_rd_d = (state_d == ACCESS) && (cmd_d.op == OP_READ);
    mem_wr_d = (state_d == ACCESS) && (cmd_d.op == OP_WRITE);
    rdy0_d   = (state_d == RESP) && (owner_d == P_CPU);
    rdy1_d   = (state_d == RESP) && (owner_d == P_AUX);
    err0_d   = rdy0_d && resp_err_c;
    err1_d   = rdy1_d && resp_err_c;
    grant_d  = (state_d != IDLE) ? grant_onehot(owner_d) : 2'b00;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      ptr_q     <= P_AUX;
      owner_q   <= P_CPU;
      cmd_q     <= '{op: OP_READ, addr: '0, data: '0};
      p0_data_q <= '0;
      p1_data_q <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      p0_data_q <= p0_data_d;
      p1_data_q <= p1_data_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      grant_q   <= grant_d;
    end
  end

  assign oMemRead  = mem_rd_q;
  assign oMemWrite = mem_wr_q;
  assign oMemAddr  = cmd_q.addr;
  assign oMemData  = cmd_q.data;
  assign oP0_Data  = p0_data_q;
  assign oP1_Data  = p1_data_q;
  assign oP0_Rdy   = rdy0_q;
  assign oP1_Rdy   = rdy1_q;
  assign oP0_Err   = err0_q;
  assign oP1_Err   = err1_q;
  assign oGrant    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected responses plus a simple memory responder.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_rd = 1'b0, p0_wr = 1'b0, p1_rd = 1'b0, p1_wr = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic [31:0] oP0_Data, oP1_Data, oMemAddr, oMemData;
  logic        oP0_Rdy, oP1_Rdy, oP0_Err, oP1_Err, oMemRead, oMemWrite;
  logic [1:0]  oGrant;
  logic [31:0] iMemData = '0;
  logic        iMemRdy = 1'b0;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic        mem_auto = 1'b1;
  logic        mem_pulse = 1'b0;
  logic [31:0] exp_p0_data = '0, exp_p1_data = '0;
  logic        rp, re;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iP0_Read  (p0_rd),
    .iP0_Write (p0_wr),
    .iP0_Addr  (p0_addr),
    .iP0_Data  (p0_wdata),
    .oP0_Data  (oP0_Data),
    .oP0_Rdy   (oP0_Rdy),
    .oP0_Err   (oP0_Err),
    .iP1_Read  (p1_rd),
    .iP1_Write (p1_wr),
    .iP1_Addr  (p1_addr),
    .iP1_Data  (p1_wdata),
    .oP1_Data  (oP1_Data),
    .oP1_Rdy   (oP1_Rdy),
    .oP1_Err   (oP1_Err),
    .oMemRead  (oMemRead),
    .oMemWrite (oMemWrite),
    .oMemAddr  (oMemAddr),
    .oMemData  (oMemData),
    .iMemData  (iMemData),
    .iMemRdy   (iMemRdy),
    .oGrant    (oGrant)
  );

  // Memory model: answers in the same cycle the strobe is seen when mem_auto is set.
  always @(posedge clk) begin
    #2;
    iMemRdy = (mem_auto && (oMemRead || oMemWrite)) || mem_pulse;
    if (iMemRdy) begin
      if (oMemWrite) mem_model[oMemAddr] = oMemData;
      iMemData = mem_model.exists(oMemAddr) ? mem_model[oMemAddr] : (32'hA5A5_0000 ^ oMemAddr);
    end else begin
      iMemData = 32'h0BAD_0BAD;
    end
  end

  task automatic wait_resp(input int budget, output int cycles, output logic got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (oP0_Rdy || oP1_Rdy) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({oMemRead, oMemWrite, oP0_Rdy, oP1_Rdy, oP0_Err, oP1_Err, oGrant} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {oMemRead, oMemWrite, oP0_Rdy, oP1_Rdy, oP0_Err, oP1_Err, oGrant});
    end
    checks++;
    if ({oMemAddr, oMemData, oP0_Data, oP1_Data} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {oMemAddr, oMemData, oP0_Data, oP1_Data});
    end
    rst = 1'b0;
  endtask

  task automatic test_tie_rr();
    int   cyc;
    logic got;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      p0_wr = 1'b1; p0_addr = 32'h10 + 32'(4 * r); p0_wdata = (r == 0) ? 32'h1111_1111 : 32'h3333_3333;
      p1_wr = 1'b1; p1_addr = 32'h20 + 32'(4 * r); p1_wdata = (r == 0) ? 32'h2222_2222 : 32'h4444_4444;
      sb.push_back('{port: 1'b0, err: 1'b0, data: exp_p0_data});
      sb.push_back('{port: 1'b1, err: 1'b0, data: exp_p1_data});
      for (int k = 0; k < 2; k++) begin
        wait_resp(12, cyc, got);
        checks++;
        if (!got || cyc != ((k == 0) ? 2 : 3)) begin
          failures++;
          $display("FAIL tie_latency round=%0d k=%0d got=%0d/%0b exp=%0d", r, k, cyc, got, (k == 0) ? 2 : 3);
        end
        rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
        e = sb.pop_front();
        checks++;
        if ({rp, re, rdat} !== {e.port, e.err, e.data}) begin
          failures++;
          $display("FAIL tie_resp got port=%0b err=%0b data=%h exp port=%0b err=%0b data=%h", rp, re, rdat, e.port, e.err, e.data);
        end
        if (rp) p1_wr = 1'b0;
        else    p0_wr = 1'b0;
      end
    end
    checks++;
    if (mem_model[32'h10] !== 32'h1111_1111 || mem_model[32'h24] !== 32'h4444_4444) begin
      failures++;
      $display("FAIL tie_mem got=%h/%h exp=11111111/44444444", mem_model[32'h10], mem_model[32'h24]);
    end
  endtask

  task automatic test_read_latency();
    mem_model[32'h40] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    p0_rd = 1'b1; p0_addr = 32'h40;
    exp_p0_data = 32'hDEAD_BEEF;
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    @(posedge clk); #1;
    checks++;
    if ({oMemRead, oMemWrite, oGrant, oMemAddr} !== {1'b1, 1'b0, 2'b01, 32'h40}) begin
      failures++;
      $display("FAIL lat_strobe got=%b/%b/%b/%h exp=1/0/01/00000040", oMemRead, oMemWrite, oGrant, oMemAddr);
    end
    @(posedge clk); #1;
    checks++;
    if (oP0_Rdy !== 1'b1 || oMemRead !== 1'b0) begin
      failures++;
      $display("FAIL lat_rdy got rdy=%0b rd=%0b exp rdy=1 rd=0", oP0_Rdy, oMemRead);
    end
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if ({rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL lat_resp got port=%0b err=%0b data=%h exp port=%0b err=%0b data=%h", rp, re, rdat, e.port, e.err, e.data);
    end
    p0_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (oP0_Rdy !== 1'b0 || oGrant !== 2'b00) begin
      failures++;
      $display("FAIL lat_pulse got rdy=%0b grant=%b exp rdy=0 grant=00", oP0_Rdy, oGrant);
    end
  endtask

  task automatic test_illegal();
    int   cyc;
    logic got;
    mem_model[32'h80] = 32'h1234_5678;
    @(posedge clk); #1;
    p1_rd = 1'b1; p1_addr = 32'h80;
    exp_p1_data = 32'h1234_5678;
    sb.push_back('{port: 1'b1, err: 1'b0, data: 32'h1234_5678});
    wait_resp(10, cyc, got);
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if (!got || cyc != 2 || {rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL p1_read got cyc=%0d port=%0b err=%0b data=%h exp cyc=2 port=%0b err=%0b data=%h", cyc, rp, re, rdat, e.port, e.err, e.data);
    end
    p1_rd = 1'b0;
    @(posedge clk); #1;
    p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 32'h84;
    sb.push_back('{port: 1'b1, err: 1'b1, data: exp_p1_data});
    @(posedge clk); #1;
    checks++;
    if ({oMemRead, oMemWrite, oGrant} !== 4'b0010) begin
      failures++;
      $display("FAIL illegal_bus got=%b exp=0010", {oMemRead, oMemWrite, oGrant});
    end
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if (oP1_Rdy !== 1'b1 || {rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL illegal_resp got rdy=%0b port=%0b err=%0b data=%h exp rdy=1 port=%0b err=%0b data=%h", oP1_Rdy, rp, re, rdat, e.port, e.err, e.data);
    end
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic test_timeout();
    int   cyc = 0;
    int   strobes = 0;
    logic got = 1'b0;
    mem_auto = 1'b0;
    @(posedge clk); #1;
    p0_rd = 1'b1; p0_addr = 32'h300;
    sb.push_back('{port: 1'b0, err: 1'b1, data: exp_p0_data});
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (oP0_Rdy || oP1_Rdy) got = 1'b1;
      else if (oMemRead) strobes++;
    end
    checks++;
    if (!got || cyc != 5 || strobes != 4) begin
      failures++;
      $display("FAIL timeout_len got cyc=%0d strobes=%0d exp cyc=5 strobes=4", cyc, strobes);
    end
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if ({rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL timeout_resp got port=%0b err=%0b data=%h exp port=%0b err=%0b data=%h", rp, re, rdat, e.port, e.err, e.data);
    end
    p0_rd = 1'b0;
    @(posedge clk); #1;
    mem_pulse = 1'b1;
    @(posedge clk); #1;
    mem_pulse = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({oP0_Rdy, oP1_Rdy, oMemRead, oGrant} !== 5'b0 || oP0_Data !== exp_p0_data) begin
      failures++;
      $display("FAIL stray_rdy got=%b data=%h exp=00000 data=%h", {oP0_Rdy, oP1_Rdy, oMemRead, oGrant}, oP0_Data, exp_p0_data);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int   cyc;
    int   stray = 0;
    logic got;
    mem_auto = 1'b0;
    @(posedge clk); #1;
    p1_wr = 1'b1; p1_addr = 32'h500; p1_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    checks++;
    if (oMemWrite !== 1'b1 || oGrant !== 2'b10) begin
      failures++;
      $display("FAIL rst_pre got wr=%0b grant=%b exp wr=1 grant=10", oMemWrite, oGrant);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({oMemWrite, oMemRead, oP1_Rdy, oGrant} !== 5'b0 || oP0_Data !== 32'h0 || oP1_Data !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got=%b d0=%h d1=%h exp=00000 d0=0 d1=0", {oMemWrite, oMemRead, oP1_Rdy, oGrant}, oP0_Data, oP1_Data);
    end
    rst = 1'b0; p1_wr = 1'b0; mem_auto = 1'b1;
    exp_p0_data = '0; exp_p1_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (oP0_Rdy || oP1_Rdy || oMemWrite) stray++;
    end
    checks++;
    if (stray != 0 || mem_model.exists(32'h500)) begin
      failures++;
      $display("FAIL rst_aborted got stray=%0d written=%0b exp stray=0 written=0", stray, mem_model.exists(32'h500));
    end
    @(posedge clk); #1;
    p0_rd = 1'b1; p0_addr = 32'h40;
    exp_p0_data = 32'hDEAD_BEEF;
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    wait_resp(10, cyc, got);
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if (!got || cyc != 2 || {rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL rst_recover got cyc=%0d port=%0b err=%0b data=%h exp cyc=2 port=%0b err=%0b data=%h", cyc, rp, re, rdat, e.port, e.err, e.data);
    end
    p0_rd = 1'b0;
  endtask

  task automatic test_addr_hold();
    int bad = 0;
    mem_model[32'h100] = 32'hCAFE_0100;
    mem_model[32'h200] = 32'hCAFE_0200;
    mem_auto = 1'b0;
    @(posedge clk); #1;
    p0_rd = 1'b1; p0_addr = 32'h100;
    exp_p0_data = 32'hCAFE_0100;
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hCAFE_0100});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) p0_addr = 32'h200;
      if (oMemAddr !== 32'h100 || oMemRead !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL addr_hold bad_cycles=%0d last_addr=%h exp bad_cycles=0 addr=00000100", bad, oMemAddr);
    end
    mem_pulse = 1'b1;
    @(posedge clk); #1;
    mem_pulse = 1'b0;
    rp = oP1_Rdy; re = rp ? oP1_Err : oP0_Err; rdat = rp ? oP1_Data : oP0_Data;
    e = sb.pop_front();
    checks++;
    if (oP0_Rdy !== 1'b1 || {rp, re, rdat} !== {e.port, e.err, e.data}) begin
      failures++;
      $display("FAIL addr_resp got rdy=%0b port=%0b err=%0b data=%h exp rdy=1 port=%0b err=%0b data=%h", oP0_Rdy, rp, re, rdat, e.port, e.err, e.data);
    end
    p0_rd = 1'b0;
    mem_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tie_rr();
    test_read_latency();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_addr_hold();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
